// File: rtl/stbus_pkg.sv
// Shared constants and types for the ST-bus master: frame geometry, idle byte,
// channel index type and the phase strobes exchanged between timing and datapath.
package stbus_pkg;

    localparam int C4_PER_FRAME = 512;
    localparam int CHANNELS     = 32;
    localparam int BITS_PER_CH  = 8;
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    typedef logic [4:0] ch_t;

    typedef struct packed {
        logic load;       // first clk of a channel slot (q = 16n, p = 0)
        logic tx_shift;   // dstx update point (p = 0, even q)
        logic rx_sample;  // 3/4-bit sample point (p = HALF_C4, odd q)
        logic rx_done;    // clk after the last bit of a channel is sampled
    } strobe_t;

endpackage

// File: rtl/stbus_timing.sv
// p/q counters of the ST-bus frame: produces c4, f0, frame_start and the
// combinational phase strobes that drive the tx/rx datapath.
module stbus_timing
    import stbus_pkg::*;
#(
    parameter int HALF_C4 = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    en_i,
    output logic    c4_o,
    output logic    f0_o,
    output logic    frame_start_o,
    output strobe_t strb_o,
    output ch_t     ch_o
);

    localparam int PW = $clog2(2 * HALF_C4);
    localparam logic [PW-1:0] P_HALF = PW'(HALF_C4);
    localparam logic [PW-1:0] P_DONE = PW'(HALF_C4 + 1);
    localparam logic [PW-1:0] P_LAST = PW'(2 * HALF_C4 - 1);
    localparam logic [8:0]    Q_LAST = 9'(C4_PER_FRAME - 1);

    logic [PW-1:0] p_q, p_d;
    logic [8:0]    q_q, q_d;
    logic          c4_q, f0_q, frame_start_q;

    always_comb begin
        p_d = p_q + 1'b1;
        q_d = q_q;
        if (p_q == P_LAST) begin
            p_d = '0;
            q_d = q_q + 1'b1;
        end
    end

    always_comb begin
        strb_o           = '0;
        strb_o.load      = en_i && (p_q == '0) && (q_q[3:0] == 4'd0);
        strb_o.tx_shift  = en_i && (p_q == '0) && !q_q[0];
        strb_o.rx_sample = en_i && (p_q == P_HALF) && q_q[0];
        strb_o.rx_done   = en_i && (p_q == P_DONE) && (q_q[3:0] == 4'hF);
    end

    assign ch_o = q_q[8:4];

    // Dropping en parks the counters at zero so the next enabled clk is q=0, p=0.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            p_q           <= '0;
            q_q           <= '0;
            c4_q          <= 1'b0;
            f0_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            p_q           <= p_d;
            q_q           <= q_d;
            c4_q          <= (p_q >= P_HALF);
            f0_q          <= (q_q != Q_LAST);
            frame_start_q <= (p_q == '0) && (q_q == 9'd0);
        end
    end

    assign c4_o          = c4_q;
    assign f0_o          = f0_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/stbus_master.sv
// ST-bus timing master with a 32-channel TDM framer: per-channel byte fetch,
// MSB-first serializer on dstx and deserializer on dsrx.
module stbus_master
    import stbus_pkg::*;
#(
    parameter int HALF_C4 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       c4,
    output logic       f0,
    output logic       dstx,
    input  logic       dsrx,
    output logic       tx_req,
    output logic [4:0] tx_ch,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_underrun,
    output logic       rx_valid,
    output logic [4:0] rx_ch,
    output logic [7:0] rx_data,
    output logic       frame_start
);

    strobe_t strb;
    ch_t     cur_ch;

    stbus_timing #(.HALF_C4(HALF_C4)) u_timing (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .c4_o          (c4),
        .f0_o          (f0),
        .frame_start_o (frame_start),
        .strb_o        (strb),
        .ch_o          (cur_ch)
    );

    // Fetch handshake: tx_req opens a window for tx_ch lasting until the next
    // load; the first clk with tx_valid high inside it (the tx_req clk
    // included) captures tx_data, later tx_valid in that window is ignored.
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;
    logic       first_q, first_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic       dstx_q, dstx_d;
    logic       tx_req_q, tx_req_d;
    ch_t        tx_ch_q, tx_ch_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic       rx_valid_q, rx_valid_d;
    ch_t        rx_ch_q, rx_ch_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] load_byte;

    always_comb begin
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        first_d       = first_q;
        tx_sr_d       = tx_sr_q;
        dstx_d        = dstx_q;
        tx_req_d      = 1'b0;
        tx_ch_d       = tx_ch_q;
        tx_underrun_d = 1'b0;
        rx_sr_d       = rx_sr_q;
        rx_valid_d    = 1'b0;
        rx_ch_d       = rx_ch_q;
        rx_data_d     = rx_data_q;
        load_byte     = buf_full_q ? buf_q : IDLE_BYTE;

        if (strb.load) begin
            // Channel 0 of the first frame has never been requested, so it is not an underrun.
            tx_underrun_d = !buf_full_q && !first_q;
            first_d       = 1'b0;
            tx_req_d      = 1'b1;
            tx_ch_d       = ch_t'(cur_ch + 5'd1);
            buf_full_d    = tx_valid;
            buf_d         = tx_valid ? tx_data : buf_q;
            dstx_d        = load_byte[7];
            tx_sr_d       = {load_byte[6:0], 1'b1};
        end else begin
            if (tx_valid && !buf_full_q) begin
                buf_full_d = 1'b1;
                buf_d      = tx_data;
            end
            if (strb.tx_shift) begin
                dstx_d  = tx_sr_q[7];
                tx_sr_d = {tx_sr_q[6:0], 1'b1};
            end
        end

        if (strb.rx_sample) begin
            rx_sr_d = {rx_sr_q[6:0], dsrx};
        end
        if (strb.rx_done) begin
            rx_valid_d = 1'b1;
            rx_ch_d    = cur_ch;
            rx_data_d  = rx_sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            buf_q         <= 8'h00;
            buf_full_q    <= 1'b0;
            first_q       <= 1'b1;
            tx_sr_q       <= IDLE_BYTE;
            dstx_q        <= 1'b1;
            tx_req_q      <= 1'b0;
            tx_ch_q       <= '0;
            tx_underrun_q <= 1'b0;
            rx_sr_q       <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_ch_q       <= '0;
            rx_data_q     <= 8'h00;
        end else begin
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            first_q       <= first_d;
            tx_sr_q       <= tx_sr_d;
            dstx_q        <= dstx_d;
            tx_req_q      <= tx_req_d;
            tx_ch_q       <= tx_ch_d;
            tx_underrun_q <= tx_underrun_d;
            rx_sr_q       <= rx_sr_d;
            rx_valid_q    <= rx_valid_d;
            rx_ch_q       <= rx_ch_d;
            rx_data_q     <= rx_data_d;
        end
    end

    assign dstx        = dstx_q;
    assign tx_req      = tx_req_q;
    assign tx_ch       = tx_ch_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_valid    = rx_valid_q;
    assign rx_ch       = rx_ch_q;
    assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_stbus_master.sv
// Directed bench for stbus_master: loopback dstx->dsrx, frame timing, underrun,
// fetch-window edges, mid-frame reset abort and en toggle.
module tb_stbus_master;

    localparam int FRAME = 2048;
    localparam logic [24:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0};

    logic       clk = 1'b0;
    logic       rst, en;
    logic       c4, f0, dstx, dsrx;
    logic       tx_req, tx_valid, tx_underrun;
    logic [4:0] tx_ch, rx_ch;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, frame_start;

    assign dsrx = dstx;

    stbus_master #(.HALF_C4(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .c4          (c4),
        .f0          (f0),
        .dstx        (dstx),
        .dsrx        (dsrx),
        .tx_req      (tx_req),
        .tx_ch       (tx_ch),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_underrun (tx_underrun),
        .rx_valid    (rx_valid),
        .rx_ch       (rx_ch),
        .rx_data     (rx_data),
        .frame_start (frame_start)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          k        = -1;
    int          epoch    = 0;
    logic [12:0] exp_q[$];
    int          und_q[$];
    int          c4_rises, f0_lows, f0_first, rx_n, treq_n;
    logic        c4_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (k=%0d epoch=%0d)", tag, got, exp, k, epoch);
    endtask

    function automatic logic [24:0] outs();
        return {c4, f0, dstx, tx_req, tx_ch, tx_underrun, rx_valid, rx_ch, rx_data, frame_start};
    endfunction

    function automatic logic [7:0] exp_byte(input int f, input int n);
        if (f == 0 && n == 0) return 8'hFF;
        if (epoch == 0 && f == 2 && n == 5) return 8'hFF;
        if (epoch == 0 && f == 3 && n == 7) return 8'hA5;
        if (epoch == 0 && f == 3 && n == 9) return 8'hFF;
        if (epoch == 0 && f == 3 && n == 10) return 8'h5A;
        return 8'(n * 8 + 1);
    endfunction

    task automatic clear_frame_counts();
        c4_rises = 0;
        f0_lows  = 0;
        f0_first = -1;
        rx_n     = 0;
        treq_n   = 0;
    endtask

    task automatic start_epoch(input int ep);
        epoch   = ep;
        k       = -1;
        c4_prev = 1'b0;
        exp_q.delete();
        clear_frame_counts();
        rst = 1'b0;
        en  = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic drive_next();
        int kn, e, f, off, rr;
        kn  = k + 1;
        e   = kn % FRAME;
        f   = kn / FRAME;
        off = e % 64;
        rr  = (e / 64 + 1) % 32;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (off == 0 && epoch == 0 && f == 3 && rr == 7) begin
            tx_valid = 1'b1;
            tx_data  = 8'hA5;
        end
        if (off == 0 && epoch == 0 && f == 3 && rr == 10) begin
            tx_valid = 1'b1;
            tx_data  = 8'h5A;
        end
        if (off == 3 && !(epoch == 0 && ((f == 2 && rr == 5) || (f == 3 && rr == 9)))) begin
            tx_valid = 1'b1;
            tx_data  = (epoch == 0 && f == 3 && rr == 7) ? 8'h3C : 8'(rr * 8 + 1);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic observe();
        int e, f;
        logic [12:0] item;
        e = k % FRAME;
        f = k / FRAME;
        if (k < 8) check("c4_phase", c4, ((e % 4) >= 2));
        if (k == 0) begin
            check("frame_start_first", frame_start, 1);
            check("f0_at_start", f0, 1);
        end
        if (k == 1) check("frame_start_pulse", frame_start, 0);
        if (c4 && !c4_prev) c4_rises++;
        c4_prev = c4;
        if (!f0) begin
            if (f0_lows == 0) f0_first = e;
            f0_lows++;
        end
        if (tx_req) begin
            treq_n++;
            check("tx_req_pos", e % 64, 0);
            check("tx_ch", tx_ch, (e / 64 + 1) % 32);
        end
        if (tx_underrun) und_q.push_back(k + epoch * 100000);
        if (e % 64 == 0) exp_q.push_back({5'(e / 64), exp_byte(f, e / 64)});
        if (rx_valid) begin
            rx_n++;
            check("rx_pos", e % 64, 63);
            if (exp_q.size() == 0) check("rx_unexpected", {rx_ch, rx_data}, 0);
            else begin
                item = exp_q.pop_front();
                check("rx_chan_data", {rx_ch, rx_data}, item);
            end
        end
        if (e == FRAME - 1) begin
            check("c4_rises_per_frame", c4_rises, 512);
            check("f0_low_clks", f0_lows, 4);
            check("f0_fall_offset", f0_first, 2044);
            check("rx_per_frame", rx_n, 32);
            check("tx_req_per_frame", treq_n, 32);
            clear_frame_counts();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        observe();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive_next();
            tick();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), RST_VEC);

        // Loopback, underrun (frame 2) and window edges (frame 3), then abort at q=200.
        start_epoch(0);
        run(4 * FRAME + 800);
        rst      = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_outputs", outs(), RST_VEC);
        check("rx_before_abort", rx_n, 12);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abort_no_rx", rx_valid, 0);
        end

        // Restart, then drop en for 10 clk mid-frame.
        start_epoch(1);
        run(FRAME + 300);
        en       = 1'b0;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("en_low_outputs", outs(), RST_VEC);
        repeat (9) begin
            @(posedge clk);
            #1;
            check("en_low_idle", {c4, f0, rx_valid, tx_req}, 4'b0100);
        end

        start_epoch(2);
        run(256);

        check("underrun_count", und_q.size(), 2);
        if (und_q.size() >= 2) begin
            check("underrun_ch5_edge", und_q[0], 2 * FRAME + 80 * 4);
            check("underrun_ch9_edge", und_q[1], 3 * FRAME + 144 * 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stbus_master.md
# stbus_master

ST-bus timing master and 32-channel serial framer: generates `c4` (4.096 MHz) and the active-low frame pulse `f0` (8 kHz) that the converter consumes, and carries one 2.048 Mbit/s TDM data pair. Outbound bytes are fetched per channel over a request/valid handshake and serialized MSB first on `dstx`. Inbound `dsrx` is deserialized and delivered per channel. Sits between the channel buffers and the ST-bus pins, at the opposite end of the link from the converter.

## Interface
- `HALF_C4`, 2: `clk` cycles per `c4` half-period; legal ≥ 2 (2 ⇒ `clk` = 16.384 MHz).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable; low holds the bus idle.
- `c4` out 1: ST-bus clock, period 2·HALF_C4 clk.
- `f0` out 1: frame pulse, active low, one `c4` period wide.
- `dstx` out 1: serial transmit data.
- `dsrx` in 1: serial receive data.
- `tx_req` out 1: one-clk pulse requesting the byte for `tx_ch`.
- `tx_ch` out 5: channel being requested.
- `tx_valid` in 1: `tx_data` valid.
- `tx_data` in 8: outbound byte.
- `tx_underrun` out 1: one-clk pulse; a channel was sent as idle.
- `rx_valid` out 1: one-clk pulse; `rx_data` complete.
- `rx_ch` out 5: channel of `rx_data`.
- `rx_data` out 8: received byte.
- `frame_start` out 1: one-clk pulse at q=0, p=0.

## Operation
- Counters: p (0..2·HALF_C4−1, clk within `c4` cycle) and q (0..511, `c4` cycle within frame). Bit index b = q>>1 (0..255); channel = b>>3; bit-in-channel = b[2:0], MSB first.
- `c4` = 0 for p < HALF_C4, 1 otherwise. `f0` = 0 throughout q=511; high otherwise.
- The first clk with `en`=1 (after `rst` or after `en` was low) is q=0, p=0.
- `en`=0 forces the counters to zero and the outputs to their reset values. The tx buffer and the rx shift register are cleared.
- TX:
  - At q=16n, p=0, the shift register loads the buffered byte for channel n. If no byte was buffered, it loads 8'hFF and pulses `tx_underrun`.
  - On the same clk, `tx_req` pulses with `tx_ch` = (n+1) mod 32, and the buffer opens a window for that channel.
  - The first `tx_valid` in the window is captured, including one on the `tx_req` clk itself. Further `tx_valid` in the same window is ignored.
  - `dstx` updates at p=0 of every even q.
- After `rst`/`en` rise, channel 0 of the first frame sends 8'hFF without an underrun pulse.
- RX:
  - `dsrx` is sampled at p=HALF_C4 of every odd q, the ¾-bit point, and shifted in MSB first.
  - After bit 7 of channel n is sampled, `rx_valid` pulses on the next clk with `rx_ch`=n and `rx_data`.
  - `rx_data`/`rx_ch` hold until the next `rx_valid`.

## Timing
- Reset/idle values: `c4`=0, `f0`=1, `dstx`=1, `tx_req`=0, `tx_ch`=0, `tx_underrun`=0, `rx_valid`=0, `rx_ch`=0, `rx_data`=8'h00, `frame_start`=0.
- All outputs are registered and change only on `clk`.
- Frame length: 512·2·HALF_C4 clk (125 µs at 16.384 MHz).
- Byte window: 16·2·HALF_C4 clk from `tx_req` to the load.
- Wrap-around: q=511→0 and channel 31→0. `tx_req` issued at channel 31 requests `tx_ch`=0 for the next frame.
- Reset or `en` fall mid-frame aborts immediately. No partial `rx_valid` is produced, and any buffered tx byte is discarded.

## Structure
- Package `stbus_pkg`: C4_PER_FRAME=512, CHANNELS=32, BITS_PER_CH=8, IDLE_BYTE=8'hFF, and the channel-index type (5 bits).
- Sub-module `stbus_timing`: the p/q counters plus `c4`, `f0`, `frame_start` and the phase strobes (load, tx_shift, rx_sample, rx_done).
- Top level: tx buffer and shifter, rx shifter.

## Test plan
- Timing (HALF_C4=2, `en`=1 after reset):
  - `c4` period is 4 clk.
  - `f0` is low for exactly 4 clk every 2048 clk.
  - `f0` falls 2044 clk after `frame_start`.
- Loopback (`dstx`→`dsrx`): answer each `tx_req` 3 clk later with `tx_data`=`tx_ch`·8+1. From frame 2 onward, `rx_valid` delivers `rx_ch`=k with `rx_data`=k·8+1 for all k, and there is no underrun.
- Underrun: withhold `tx_valid` for channel 5 only → `tx_underrun` pulses at q=80, p=0, and channel 5 reads back 8'hFF.
- Window edges:
  - `tx_valid` with 8'hA5 on the `tx_req` clk, then 8'h3C later in the same window → 8'hA5 is sent.
  - `tx_valid` on the load clk counts for the next channel.
- Abort: assert `rst` at q=200 mid-byte → the next clk shows all outputs at their reset values, and no `rx_valid` fires for channel 12.
- `en` toggle: drop `en` for 10 clk, then raise it → `frame_start` fires on the first `en`=1 clk, and channel 0 sends 8'hFF with no `tx_underrun`.
